// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel 3x3 window generator: pixel width,
// default frame geometry and the counter width derivation.
package sobel_pkg;

    localparam int PIXEL_W            = 8;
    localparam int DEFAULT_IMG_WIDTH  = 64;
    localparam int DEFAULT_IMG_HEIGHT = 48;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One row of pixel storage: combinational read and synchronous write share
// one address, so a same-cycle read returns the pre-write contents.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_IMG_WIDTH,
    parameter int ADDR_W = counter_width(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [PIXEL_W-1:0] wr_data,
    output logic [PIXEL_W-1:0] rd_data
);

    // Contents are deliberately unreset; the window logic never exposes a
    // column before the current frame has rewritten it.
    pixel_t mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window.sv
// Raster-order 3x3 window generator feeding a Sobel edge detector; emits a
// window for every accepted pixel whose row and column are both at least 2.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_valid,
    input  logic               sof,
    output logic [PIXEL_W-1:0] p0,
    output logic [PIXEL_W-1:0] p1,
    output logic [PIXEL_W-1:0] p2,
    output logic [PIXEL_W-1:0] p3,
    output logic [PIXEL_W-1:0] p4,
    output logic [PIXEL_W-1:0] p5,
    output logic [PIXEL_W-1:0] p6,
    output logic [PIXEL_W-1:0] p7,
    output logic [PIXEL_W-1:0] p8,
    output logic               window_valid,
    output logic               frame_done
);

    localparam int COL_W = counter_width(IMG_WIDTH);
    localparam int ROW_W = counter_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    pixel_t           lb0_rd;
    pixel_t           lb1_rd;

    // sof forces the accepted pixel to (0,0) whatever the counters say.
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pixel_valid) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // lb0 holds the previous row, lb1 the one above it.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .ADDR_W(COL_W)
    ) u_lb0 (
        .clk    (clk),
        .wr_en  (pixel_valid),
        .addr   (cur_col),
        .wr_data(pixel_in),
        .rd_data(lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .ADDR_W(COL_W)
    ) u_lb1 (
        .clk    (clk),
        .wr_en  (pixel_valid),
        .addr   (cur_col),
        .wr_data(lb0_rd),
        .rd_data(lb1_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= '0; p1 <= '0; p2 <= '0;
            p3 <= '0; p4 <= '0; p5 <= '0;
            p6 <= '0; p7 <= '0; p8 <= '0;
        end else if (pixel_valid) begin
            p0 <= p1; p1 <= p2; p2 <= lb1_rd;
            p3 <= p4; p4 <= p5; p5 <= lb0_rd;
            p6 <= p7; p7 <= p8; p8 <= pixel_in;
        end
    end

    // Validity keys off the post-sof position, so rows left in the line
    // buffers by an abandoned frame can never be flagged as a window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= pixel_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            frame_done   <= pixel_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// Scoreboard bench for sobel_window on a 4x4 frame: an image-array model
// predicts each cycle's outputs and a monitor compares them at negedge.
module tb_sobel_window;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        int          due;
        bit          is_win;
        bit          fd;
        logic [71:0] win;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pixel_in = '0;
    logic       pixel_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic       window_valid;
    logic       frame_done;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    exp_t q[$];

    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    bit          hold_known = 0;
    logic [71:0] last_win = '0;

    sobel_window #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
        .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .window_valid(window_valid),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; accepted pixels update the image model.
    task automatic applyStimulus(input logic [7:0] pix, input bit valid, input bit start);
        exp_t e;
        @(negedge clk);
        pixel_in    = pix;
        pixel_valid = valid;
        sof         = start;
        if (valid) begin
            if (start) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = pix;
            e.due    = cyc + 1;
            e.is_win = (mr >= 2) && (mc >= 2);
            e.fd     = (mr == H - 1) && (mc == W - 1);
            e.win    = '0;
            if (e.is_win) begin
                e.win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                         img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                         img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
            end
            q.push_back(e);
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
    endtask

    task automatic rampFrame(input bit with_sof);
        for (int i = 0; i < W * H; i++) begin
            applyStimulus(8'(i), 1'b1, with_sof && (i == 0));
        end
    endtask

    // Asynchronous reset pulse placed entirely between two clock edges.
    task automatic resetPulse();
        @(negedge clk);
        pixel_valid = 1'b0;
        sof         = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, 72'd0);
        checkOutput("async_reset_valid", {window_valid, frame_done}, 72'd0);
        rst = 1'b0;
        mr = 0;
        mc = 0;
        hold_known = 0;
    endtask

    // Monitor: each negedge either retires a due expectation or checks idle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                checkOutput("window_valid", window_valid, e.is_win);
                checkOutput("frame_done", frame_done, e.fd);
                if (e.is_win) begin
                    checkOutput("window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, e.win);
                    last_win   = e.win;
                    hold_known = 1;
                end else begin
                    hold_known = 0;
                end
            end else begin
                checkOutput("idle_valid", {window_valid, frame_done}, 72'd0);
                if (hold_known) begin
                    checkOutput("held_window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, last_win);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, 72'd0);
        checkOutput("reset_valid", {window_valid, frame_done}, 72'd0);
        rst = 1'b0;

        rampFrame(1'b1);

        // Gap after (2,2), with a stray unqualified sof inside it.
        for (int i = 0; i < W * H; i++) begin
            applyStimulus(8'(i), 1'b1, i == 0);
            if (i == 10) begin
                applyStimulus(8'd0, 1'b0, 1'b0);
                applyStimulus(8'd99, 1'b0, 1'b1);
                applyStimulus(8'd0, 1'b0, 1'b0);
            end
        end

        // Abandon a frame at (2,1) with a new sof.
        for (int i = 0; i < 9; i++) applyStimulus(8'(i), 1'b1, i == 0);
        rampFrame(1'b1);

        // Reset mid-row, then restart without sof.
        for (int i = 0; i < 6; i++) applyStimulus(8'(i + 50), 1'b1, i == 0);
        resetPulse();
        rampFrame(1'b0);

        rampFrame(1'b1);
        rampFrame(1'b0);

        // Random pixels with random bubbles and occasional restarts.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W * H; i++) begin
                while ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom), 1'b0, 1'($urandom));
                applyStimulus(8'($urandom), 1'b1, (i == 0) || ($urandom_range(0, 19) == 0));
            end
        end

        repeat (4) applyStimulus(8'd0, 1'b0, 1'b0);
        checkOutput("scoreboard_drained", 72'(q.size()), 72'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
